// File: rtl/cluster_cken_seq.sv
// Cluster clock-enable sequencer: staggers per-cluster enables on power-up,
// then releases global reset/debug-init; reverses the order on power-down.
module cluster_cken_seq #(
    parameter int NCLUST    = 4,
    parameter int GAP       = 4,
    parameter int RST_HOLD  = 8,
    parameter int DBG_PULSE = 4
) (
    input  logic              gclk,
    input  logic              arst,
    input  logic              start,
    input  logic              stop,
    input  logic              dbg_req,
    output logic [NCLUST-1:0] cluster_cken,
    output logic              grst_l,
    output logic              gdbginit_l,
    output logic              ready,
    output logic              busy
);

    localparam int MAX_GR = (GAP > RST_HOLD) ? GAP : RST_HOLD;
    localparam int MAXV   = (MAX_GR > DBG_PULSE) ? MAX_GR : DBG_PULSE;
    localparam int CW     = $clog2(MAXV) + 1;

    // Counter is loaded with N-1 so a phase lasts exactly N cycles.
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DBG_LD  = CW'(DBG_PULSE - 1);

    localparam logic [2:0] S_OFF  = 3'd0;
    localparam logic [2:0] S_RAMP = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DBG  = 3'd4;
    localparam logic [2:0] S_DOWN = 3'd5;

    logic [2:0]        st_q, st_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_dec;
    logic [NCLUST-1:0] cken_q, cken_d;
    logic              cnt_zero;

    assign cnt_dec  = cnt_q - CW'(1);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        cken_d = cken_q;
        case (st_q)
            S_OFF: begin
                if (start) begin
                    cken_d = NCLUST'(1);
                    if (NCLUST == 1) begin
                        st_d  = S_HOLD;
                        cnt_d = HOLD_LD;
                    end else begin
                        st_d  = S_RAMP;
                        cnt_d = GAP_LD;
                    end
                end
            end
            S_RAMP: begin
                if (stop) begin
                    st_d  = S_DOWN;
                    cnt_d = HOLD_LD;
                end else if (cnt_zero) begin
                    cken_d = (cken_q << 1) | NCLUST'(1);
                    if (cken_d[NCLUST-1]) begin
                        st_d  = S_HOLD;
                        cnt_d = HOLD_LD;
                    end else begin
                        cnt_d = GAP_LD;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    st_d  = S_DOWN;
                    cnt_d = HOLD_LD;
                end else if (cnt_zero) begin
                    st_d = S_RUN;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_RUN: begin
                if (stop) begin
                    st_d  = S_DOWN;
                    cnt_d = HOLD_LD;
                end else if (dbg_req) begin
                    st_d  = S_DBG;
                    cnt_d = DBG_LD;
                end
            end
            S_DBG: begin
                if (stop) begin
                    st_d  = S_DOWN;
                    cnt_d = HOLD_LD;
                end else if (cnt_zero) begin
                    st_d = S_RUN;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_DOWN: begin
                if (cnt_zero) begin
                    cken_d = cken_q >> 1;
                    if (cken_d == '0) begin
                        st_d  = S_OFF;
                        cnt_d = '0;
                    end else begin
                        cnt_d = GAP_LD;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                st_d   = S_OFF;
                cnt_d  = '0;
                cken_d = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they align with cken.
    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            st_q         <= S_OFF;
            cnt_q        <= '0;
            cken_q       <= '0;
            cluster_cken <= '0;
            grst_l       <= 1'b0;
            gdbginit_l   <= 1'b0;
            ready        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            cken_q       <= cken_d;
            cluster_cken <= cken_d;
            grst_l       <= (st_d == S_RUN) || (st_d == S_DBG);
            gdbginit_l   <= (st_d == S_RUN);
            ready        <= (st_d == S_RUN);
            busy         <= (st_d == S_RAMP) || (st_d == S_HOLD) ||
                            (st_d == S_DBG)  || (st_d == S_DOWN);
        end
    end

endmodule

// File: tb/tb_cluster_cken_seq.sv
// Bench for cluster_cken_seq: timestamp-based reference model feeding a
// scoreboard queue that a free-running monitor drains once per cycle.
module tb_cluster_cken_seq;

    localparam int NC = 4;
    localparam int GP = 4;
    localparam int RH = 8;
    localparam int DP = 4;

    logic          gclk = 1'b0;
    logic          arst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          dbg_req = 1'b0;
    logic [NC-1:0] cluster_cken;
    logic          grst_l;
    logic          gdbginit_l;
    logic          ready;
    logic          busy;

    typedef struct packed {
        logic [NC-1:0] cken;
        logic          grst_l;
        logic          gdbg_l;
        logic          ready;
        logic          busy;
    } exp_t;

    typedef enum int {M_OFF, M_UP, M_HOLD, M_RUN, M_DBG, M_DOWN} mode_t;

    exp_t  q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    pushed = 0;
    int    popped = 0;
    mode_t mode = M_OFF;
    int    nbits = 0;
    int    evt = 0;
    int    cyc = 0;

    always #5 gclk = ~gclk;

    cluster_cken_seq #(
        .NCLUST(NC), .GAP(GP), .RST_HOLD(RH), .DBG_PULSE(DP)
    ) dut (
        .gclk(gclk),
        .arst(arst),
        .start(start),
        .stop(stop),
        .dbg_req(dbg_req),
        .cluster_cken(cluster_cken),
        .grst_l(grst_l),
        .gdbginit_l(gdbginit_l),
        .ready(ready),
        .busy(busy)
    );

    function automatic exp_t dut_out();
        return exp_t'({cluster_cken, grst_l, gdbginit_l, ready, busy});
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.cken   = NC'((1 << nbits) - 1);
        e.grst_l = (mode == M_RUN) || (mode == M_DBG);
        e.gdbg_l = (mode == M_RUN);
        e.ready  = (mode == M_RUN);
        e.busy   = (mode != M_OFF) && (mode != M_RUN);
        return e;
    endfunction

    task automatic go_down();
        mode = M_DOWN;
        evt  = cyc + RH;
    endtask

    // One clock edge of the reference: event times are absolute cycle stamps.
    task automatic model_step(input logic s, input logic p, input logic d);
        cyc++;
        case (mode)
            M_OFF: if (s) begin
                nbits = 1;
                if (nbits == NC) begin mode = M_HOLD; evt = cyc + RH; end
                else begin mode = M_UP; evt = cyc + GP; end
            end
            M_UP: if (p) go_down();
            else if (cyc == evt) begin
                nbits++;
                if (nbits == NC) begin mode = M_HOLD; evt = cyc + RH; end
                else evt = cyc + GP;
            end
            M_HOLD: if (p) go_down();
            else if (cyc == evt) mode = M_RUN;
            M_RUN: if (p) go_down();
            else if (d) begin mode = M_DBG; evt = cyc + DP; end
            M_DBG: if (p) go_down();
            else if (cyc == evt) mode = M_RUN;
            M_DOWN: if (cyc == evt) begin
                nbits--;
                if (nbits == 0) mode = M_OFF;
                else evt = cyc + GP;
            end
            default: mode = M_OFF;
        endcase
    endtask

    task automatic check(input string name, input exp_t act, input exp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got cken=%b grst_l=%b gdbginit_l=%b ready=%b busy=%b, expected cken=%b grst_l=%b gdbginit_l=%b ready=%b busy=%b",
                     name, $time, act.cken, act.grst_l, act.gdbg_l, act.ready, act.busy,
                     exp.cken, exp.grst_l, exp.gdbg_l, exp.ready, exp.busy);
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic d);
        @(negedge gclk);
        start   = s;
        stop    = p;
        dbg_req = d;
        model_step(s, p, d);
        q.push_back(model_out());
        pushed++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge gclk);
            #2;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                popped++;
                check("cycle", dut_out(), e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 arst = 1'b1;
        repeat (2) @(negedge gclk);
        #1 check("reset_state", dut_out(), exp_t'(0));
        @(negedge gclk);
        arst = 1'b0;
        idle(3);
        // start+stop together in OFF: ramp proceeds
        drive(1'b1, 1'b1, 1'b0);
        idle(25);
        drive(1'b0, 1'b0, 1'b1);
        idle(8);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        // stop wins over dbg_req in RUN
        drive(1'b0, 1'b1, 1'b1);
        idle(25);
        // abort while cken=0011
        drive(1'b1, 1'b0, 1'b0);
        idle(5);
        drive(1'b0, 1'b1, 1'b0);
        idle(20);
        // stop during the debug pulse
        drive(1'b1, 1'b0, 1'b0);
        idle(22);
        drive(1'b0, 1'b0, 1'b1);
        idle(1);
        drive(1'b0, 1'b1, 1'b0);
        idle(25);
        // asynchronous reset in RUN, checked before the next edge
        drive(1'b1, 1'b0, 1'b0);
        idle(24);
        @(negedge gclk);
        start = 1'b0; stop = 1'b0; dbg_req = 1'b0;
        #2 arst = 1'b1;
        #1 check("async_reset", dut_out(), exp_t'(0));
        @(negedge gclk);
        arst  = 1'b0;
        mode  = M_OFF;
        nbits = 0;
        drive(1'b1, 1'b0, 1'b0);
        idle(25);
        repeat (3000)
            drive($urandom_range(0, 7) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) == 0);
        repeat (3) @(negedge gclk);
        vectors++;
        if (popped != pushed) begin
            miscompares++;
            $display("FAIL drain: popped %0d, expected %0d", popped, pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
